// File: rtl/trace_cache_ctrl_if.sv
// Memory-trace handshake bundle between the trace producer and the cache controller.
// Handshake: the producer pulses trace_ready for one cycle with mem_addr valid while the
// controller is idle; the controller answers with a one-cycle updated pulse (hit or miss
// one-hot alongside it), and the producer may raise trace_ready again the following cycle.
interface trace_cache_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              trace_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              flush;
    logic              updated;
    logic              hit;
    logic              miss;
    logic              busy;
    logic [15:0]       hit_count;
    logic [15:0]       miss_count;

    modport master (
        output trace_ready, mem_addr, flush,
        input  updated, hit, miss, busy, hit_count, miss_count
    );

    modport slave (
        input  trace_ready, mem_addr, flush,
        output updated, hit, miss, busy, hit_count, miss_count
    );
endinterface

// File: rtl/trace_cache_ctrl.sv
// Direct-mapped tag-store controller at the consumer end of a memory-trace handshake.
// One address per trace_ready pulse; misses cost a fixed refill latency and replace the line.
module trace_cache_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 4,
    parameter int INDEX_W  = 4,
    parameter int MISS_LAT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    trace_cache_ctrl_if.slave    bus,
    output logic [1:0]           state_dbg
);
    localparam int TAG_W = ADDR_W - OFFSET_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;
    localparam int CNT_W = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MISS_LAT - 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, DONE} state_t;

    state_t                    state, next_state;
    logic [INDEX_W-1:0]        idx_q;
    logic [TAG_W-1:0]          tag_q;
    logic [CNT_W-1:0]          cnt;
    logic                      hit_q;
    logic [LINES-1:0]          valid;
    logic [TAG_W-1:0]          tag_mem [LINES];
    logic                      lookup_hit;
    logic                      refill_done;
    logic                      updated_r, hit_r, miss_r, busy_r;
    logic [15:0]               hit_cnt_r, miss_cnt_r;
    logic                      unused_offset;

    // Byte offset never affects the lookup.
    assign unused_offset = ^bus.mem_addr[OFFSET_W-1:0];

    assign lookup_hit  = valid[idx_q] && (tag_mem[idx_q] == tag_q);
    assign refill_done = (state == REFILL) && (cnt == '0);
    assign state_dbg   = state;

    assign bus.updated    = updated_r;
    assign bus.hit        = hit_r;
    assign bus.miss       = miss_r;
    assign bus.busy       = busy_r;
    assign bus.hit_count  = hit_cnt_r;
    assign bus.miss_count = miss_cnt_r;

    // Next-state logic; trace_ready is only looked at in IDLE, so pulses while busy are dropped.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.trace_ready) next_state = LOOKUP;
            LOOKUP:  next_state = lookup_hit ? DONE : REFILL;
            REFILL:  if (cnt == '0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Address latch, lookup result and refill countdown.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
            tag_q <= '0;
            hit_q <= 1'b0;
            cnt   <= '0;
        end else begin
            if (state == IDLE && bus.trace_ready) begin
                idx_q <= bus.mem_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
                tag_q <= bus.mem_addr[ADDR_W-1:OFFSET_W+INDEX_W];
            end
            if (state == LOOKUP) begin
                hit_q <= lookup_hit;
                cnt   <= CNT_LOAD;
            end else if (state == REFILL && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Valid bits: flush beats a refill write landing on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           valid <= '0;
        else if (bus.flush)   valid <= '0;
        else if (refill_done) valid[idx_q] <= 1'b1;
    end

    // Tag store is only meaningful where valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (refill_done) tag_mem[idx_q] <= tag_q;
    end

    // Registered outputs: the completion pulse and counters follow the DONE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            updated_r  <= 1'b0;
            hit_r      <= 1'b0;
            miss_r     <= 1'b0;
            busy_r     <= 1'b0;
            hit_cnt_r  <= '0;
            miss_cnt_r <= '0;
        end else begin
            updated_r <= (state == DONE);
            hit_r     <= (state == DONE) && hit_q;
            miss_r    <= (state == DONE) && !hit_q;
            busy_r    <= (next_state != IDLE);
            if (state == DONE) begin
                if (hit_q && hit_cnt_r != 16'hFFFF)   hit_cnt_r  <= hit_cnt_r + 16'd1;
                if (!hit_q && miss_cnt_r != 16'hFFFF) miss_cnt_r <= miss_cnt_r + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_trace_cache_ctrl.sv
// Directed bench for trace_cache_ctrl: latency, hit/miss flags, counters, flush and reset corners.
module tb_trace_cache_ctrl;
    logic       clk;
    logic       reset;
    logic [1:0] state_dbg;
    int         total;
    int         bad;

    trace_cache_ctrl_if #(.ADDR_W(32)) bus ();

    trace_cache_ctrl #(
        .ADDR_W(32), .OFFSET_W(4), .INDEX_W(4), .MISS_LAT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave),
        .state_dbg(state_dbg)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset pulse for a few cycles, released on a falling edge.
    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // One trace access. flush_edge: cycle index whose edge also sees flush (0 = with trace_ready,
    // -1 = none). extra_edge: edge at which a stray trace_ready/extra_addr is presented.
    // lat = first cycle updated is seen after the sampling edge, -1 if never within budget.
    task automatic do_access(input logic [31:0] addr, input int flush_edge, input int extra_edge,
                             input logic [31:0] extra_addr, output int lat, output logic h,
                             output logic m, output logic busy_mid, output logic upd_after);
        lat = -1; h = 1'b0; m = 1'b0; busy_mid = 1'b0;
        @(negedge clk);
        bus.trace_ready = 1'b1;
        bus.mem_addr    = addr;
        bus.flush       = (flush_edge == 0);
        @(posedge clk);
        #1;
        bus.trace_ready = 1'b0;
        bus.flush       = 1'b0;
        busy_mid        = bus.busy;
        for (int k = 1; k <= 40; k++) begin
            if (flush_edge == k) bus.flush = 1'b1;
            if (extra_edge == k) begin
                bus.trace_ready = 1'b1;
                bus.mem_addr    = extra_addr;
            end
            @(posedge clk);
            #1;
            bus.flush       = 1'b0;
            bus.trace_ready = 1'b0;
            if (bus.updated) begin
                lat = k;
                h   = bus.hit;
                m   = bus.miss;
                break;
            end
        end
        @(posedge clk);
        #1;
        upd_after = bus.updated;
    endtask

    // Counts updated pulses seen over n cycles with no stimulus.
    task automatic quiet_cycles(input int n, output int pulses);
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (bus.updated) pulses++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.trace_ready = 1'b0;
        bus.mem_addr    = '0;
        bus.flush       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total += 6;
        if (bus.updated !== 1'b0) begin bad++; $display("FAIL reset_updated got=%b exp=0", bus.updated); end
        if (bus.hit !== 1'b0)     begin bad++; $display("FAIL reset_hit got=%b exp=0", bus.hit); end
        if (bus.miss !== 1'b0)    begin bad++; $display("FAIL reset_miss got=%b exp=0", bus.miss); end
        if (bus.busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        if (bus.hit_count !== 16'd0 || bus.miss_count !== 16'd0) begin
            bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", bus.hit_count, bus.miss_count);
        end
        if (state_dbg !== 2'd0)   begin bad++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.updated !== 1'b0) begin
            bad++; $display("FAIL reset_release got busy=%b upd=%b exp=0/0", bus.busy, bus.updated);
        end
    endtask

    task automatic test_cold_miss();
        int lat; logic h, m, bm, ua;
        do_access(32'h0443_2090, -1, -1, '0, lat, h, m, bm, ua);
        total += 5;
        if (lat !== 6)   begin bad++; $display("FAIL cold_miss_latency got=%0d exp=6", lat); end
        if ({h, m} !== 2'b01) begin bad++; $display("FAIL cold_miss_flags got=%b%b exp=01", h, m); end
        if (bus.miss_count !== 16'd1) begin bad++; $display("FAIL cold_miss_count got=%0d exp=1", bus.miss_count); end
        if (bm !== 1'b1) begin bad++; $display("FAIL cold_miss_busy got=%b exp=1", bm); end
        if (ua !== 1'b0) begin bad++; $display("FAIL cold_miss_pulse_width got=%b exp=0", ua); end
    endtask

    task automatic test_hit();
        int lat; logic h, m, bm, ua;
        do_access(32'h0443_2091, -1, -1, '0, lat, h, m, bm, ua);
        total += 4;
        if (lat !== 2)   begin bad++; $display("FAIL hit_latency got=%0d exp=2", lat); end
        if ({h, m} !== 2'b10) begin bad++; $display("FAIL hit_flags got=%b%b exp=10", h, m); end
        if (bus.hit_count !== 16'd1) begin bad++; $display("FAIL hit_count got=%0d exp=1", bus.hit_count); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL hit_idle_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [10];
        logic        exp_h [10];
        int lat; logic h, m, bm, ua;
        for (int i = 0; i < 8; i++) begin
            addrs[i] = 32'h0443_2090 + 32'(i);
            exp_h[i] = (i != 0);
        end
        addrs[8] = 32'h0443_2090; exp_h[8] = 1'b1;
        addrs[9] = 32'h0443_2FC5; exp_h[9] = 1'b0;
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            do_access(addrs[i], -1, -1, '0, lat, h, m, bm, ua);
            total++;
            if (h !== exp_h[i] || m !== !exp_h[i] || lat !== (exp_h[i] ? 2 : 6)) begin
                bad++;
                $display("FAIL trace_%0d got hit=%b miss=%b lat=%0d exp hit=%b", i, h, m, lat, exp_h[i]);
            end
        end
        total++;
        if (bus.hit_count !== 16'd8 || bus.miss_count !== 16'd2) begin
            bad++; $display("FAIL trace_counts got=%0d/%0d exp=8/2", bus.hit_count, bus.miss_count);
        end
    endtask

    task automatic test_conflict_flush();
        int lat; logic h, m, bm, ua;
        do_access(32'h1443_2090, -1, -1, '0, lat, h, m, bm, ua);
        total++;
        if (m !== 1'b1 || lat !== 6) begin bad++; $display("FAIL conflict_new_tag got miss=%b lat=%0d exp 1/6", m, lat); end
        do_access(32'h0443_2090, -1, -1, '0, lat, h, m, bm, ua);
        total++;
        if (m !== 1'b1) begin bad++; $display("FAIL conflict_evicted got miss=%b exp=1", m); end
        do_access(32'h0443_2091, -1, -1, '0, lat, h, m, bm, ua);
        total++;
        if (h !== 1'b1) begin bad++; $display("FAIL conflict_refilled got hit=%b exp=1", h); end
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        do_access(32'h0443_2090, -1, -1, '0, lat, h, m, bm, ua);
        total++;
        if (m !== 1'b1) begin bad++; $display("FAIL flush_idle got miss=%b exp=1", m); end
        do_access(32'h0443_2090, 0, -1, '0, lat, h, m, bm, ua);
        total++;
        if (m !== 1'b1 || lat !== 6) begin bad++; $display("FAIL flush_with_ready got miss=%b lat=%0d exp 1/6", m, lat); end
        total++;
        if (bus.hit_count !== 16'd9 || bus.miss_count !== 16'd6) begin
            bad++; $display("FAIL conflict_counts got=%0d/%0d exp=9/6", bus.hit_count, bus.miss_count);
        end
    endtask

    task automatic test_flush_refill();
        int lat; logic h, m, bm, ua;
        // Flush on the refill-write edge: the line must stay invalid.
        do_access(32'h0000_00A0, 5, -1, '0, lat, h, m, bm, ua);
        total++;
        if (m !== 1'b1 || lat !== 6) begin bad++; $display("FAIL flush_write_edge got miss=%b lat=%0d exp 1/6", m, lat); end
        do_access(32'h0000_00A4, -1, -1, '0, lat, h, m, bm, ua);
        total++;
        if (m !== 1'b1) begin bad++; $display("FAIL flush_write_edge_after got miss=%b exp=1", m); end
        // Flush earlier in the refill: the write still lands afterwards.
        do_access(32'h0000_00B0, 3, -1, '0, lat, h, m, bm, ua);
        total++;
        if (m !== 1'b1) begin bad++; $display("FAIL flush_mid_refill got miss=%b exp=1", m); end
        do_access(32'h0000_00B4, -1, -1, '0, lat, h, m, bm, ua);
        total++;
        if (h !== 1'b1 || lat !== 2) begin bad++; $display("FAIL flush_mid_refill_after got hit=%b lat=%0d exp 1/2", h, lat); end
    endtask

    task automatic test_busy_ignored();
        int lat, pulses; logic h, m, bm, ua;
        pulse_reset();
        do_access(32'h0000_00C0, -1, 2, 32'h0000_00D0, lat, h, m, bm, ua);
        quiet_cycles(10, pulses);
        total += 4;
        if (m !== 1'b1 || lat !== 6) begin bad++; $display("FAIL busy_access got miss=%b lat=%0d exp 1/6", m, lat); end
        if (ua !== 1'b0 || pulses !== 0) begin bad++; $display("FAIL busy_extra_updated got %0d pulses exp=0", pulses + int'(ua)); end
        if (bus.miss_count !== 16'd1 || bus.hit_count !== 16'd0) begin
            bad++; $display("FAIL busy_counts got=%0d/%0d exp=0/1", bus.hit_count, bus.miss_count);
        end
        if (state_dbg !== 2'd0) begin bad++; $display("FAIL busy_state got=%0d exp=0", state_dbg); end
    endtask

    task automatic test_reset_mid_refill();
        int lat, pulses; logic h, m, bm, ua;
        @(negedge clk);
        bus.trace_ready = 1'b1;
        bus.mem_addr    = 32'h0000_00E0;
        @(posedge clk);
        #1;
        bus.trace_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        total += 2;
        if (state_dbg !== 2'd0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL midreset_state got state=%0d busy=%b exp=0/0", state_dbg, bus.busy);
        end
        if (bus.miss_count !== 16'd0 || bus.hit_count !== 16'd0) begin
            bad++; $display("FAIL midreset_counts got=%0d/%0d exp=0/0", bus.hit_count, bus.miss_count);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        quiet_cycles(8, pulses);
        total++;
        if (pulses !== 0) begin bad++; $display("FAIL midreset_no_update got=%0d exp=0", pulses); end
        do_access(32'h0000_00E0, -1, -1, '0, lat, h, m, bm, ua);
        total++;
        if (m !== 1'b1 || lat !== 6 || bus.miss_count !== 16'd1) begin
            bad++; $display("FAIL midreset_line_invalid got miss=%b lat=%0d cnt=%0d exp 1/6/1", m, lat, bus.miss_count);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_back_to_back();
        test_conflict_flush();
        test_flush_refill();
        test_busy_ignored();
        test_reset_mid_refill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
